// File: rtl/mio_arb_pkg.sv
// Shared definitions for the two-master MIO bus arbiter: FSM encoding,
// the latched transaction record and the default read wait.
package mio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam int unsigned RD_WAIT_DEFAULT = 1;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    // Everything the bus needs is captured at grant time so masters may change
    // their inputs freely once the transaction is in flight.
    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    localparam xfer_t XFER_NONE = '{owner: 1'b0, we: 1'b0, addr: 32'd0, wdata: 32'd0};

    function automatic xfer_t mk_xfer(
        input logic        owner,
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        xfer_t x;
        x.owner = owner;
        x.we    = we;
        x.addr  = addr;
        x.wdata = wdata;
        return x;
    endfunction

endpackage

// File: rtl/mio_rr_picker.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// master that was not granted last.
module mio_rr_picker
    import mio_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // Pure combinational grant decode.
    always_comb begin
        grant = MST_M0;
        valid = 1'b0;
        case (req)
            2'b01: begin
                grant = MST_M0;
                valid = 1'b1;
            end
            2'b10: begin
                grant = MST_M1;
                valid = 1'b1;
            end
            2'b11: begin
                grant = ~last;
                valid = 1'b1;
            end
            default: begin
                grant = MST_M0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Arbitrates two masters onto a single MIO bus, one transaction at a time,
// using an IDLE -> XFER -> DONE sequence with round-robin tie breaking.
module mio_bus_arbiter
    import mio_arb_pkg::*;
#(
    parameter int unsigned RD_WAIT = RD_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] RD_WAIT_C = 3'(RD_WAIT);

    arb_state_e  state_q, state_d;
    logic        last_q, last_d;
    xfer_t       xfer_q, xfer_d;
    logic [2:0]  wait_q, wait_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    logic [1:0]  req_s;
    logic        grant_s;
    logic        valid_s;
    logic        rd_last_s;

    assign req_s = {m1_req, m0_req};

    mio_rr_picker u_picker (
        .req   (req_s),
        .last  (last_q),
        .grant (grant_s),
        .valid (valid_s)
    );

    // A read's final XFER cycle is the one where the wait counter reaches RD_WAIT.
    assign rd_last_s = (!xfer_q.we) && (wait_q == RD_WAIT_C);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= MST_M1;
            xfer_q     <= XFER_NONE;
            wait_q     <= 3'd0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            xfer_q     <= xfer_d;
            wait_q     <= wait_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_s) begin
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (xfer_q.we || rd_last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = XFER;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant latching, wait counting and read-data capture.
    always_comb begin
        last_d     = last_q;
        xfer_d     = xfer_q;
        wait_d     = wait_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            IDLE: begin
                wait_d = 3'd0;
                if (valid_s) begin
                    last_d = grant_s;
                    if (grant_s == MST_M1) begin
                        xfer_d = mk_xfer(MST_M1, m1_we, m1_addr, m1_wdata);
                    end else begin
                        xfer_d = mk_xfer(MST_M0, m0_we, m0_addr, m0_wdata);
                    end
                end else begin
                    xfer_d = xfer_q;
                end
            end
            XFER: begin
                if (xfer_q.we) begin
                    wait_d = 3'd0;
                end else if (rd_last_s) begin
                    wait_d = 3'd0;
                    if (xfer_q.owner == MST_M1) begin
                        m1_rdata_d = bus_rdata;
                    end else begin
                        m0_rdata_d = bus_rdata;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            DONE:    wait_d = 3'd0;
            default: wait_d = 3'd0;
        endcase
    end

    // Output decode; the bus is quiet outside XFER.
    always_comb begin
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        bus_we    = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        case (state_q)
            XFER: begin
                bus_addr  = xfer_q.addr;
                bus_wdata = xfer_q.wdata;
                bus_we    = xfer_q.we;
            end
            DONE: begin
                m0_ack = (xfer_q.owner == MST_M0);
                m1_ack = (xfer_q.owner == MST_M1);
            end
            default: begin
                bus_addr  = 32'd0;
                bus_wdata = 32'd0;
                bus_we    = 1'b0;
            end
        endcase
    end

    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed self-checking bench for mio_bus_arbiter with RD_WAIT = 1.
module tb_mio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_we;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.RD_WAIT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_rdata (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".m0_ack"},    {31'd0, m0_ack}, 32'd0);
        chk({tag, ".m1_ack"},    {31'd0, m1_ack}, 32'd0);
        chk({tag, ".bus_we"},    {31'd0, bus_we}, 32'd0);
        chk({tag, ".bus_addr"},  bus_addr,        32'd0);
        chk({tag, ".bus_wdata"}, bus_wdata,       32'd0);
        chk({tag, ".m0_rdata"},  m0_rdata,        32'd0);
        chk({tag, ".m1_rdata"},  m1_rdata,        32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic own;
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        bus_rdata = 32'd0;
        do_reset();
        chk_all_zero("reset");

        // Lone m0 write.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0010; m0_wdata = 32'hDEAD_BEEF;
        step();
        chk("wr.bus_we",    {31'd0, bus_we}, 32'd1);
        chk("wr.bus_addr",  bus_addr,        32'h0000_0010);
        chk("wr.bus_wdata", bus_wdata,       32'hDEAD_BEEF);
        chk("wr.early_ack", {31'd0, m0_ack}, 32'd0);
        step();
        chk("wr.m0_ack",    {31'd0, m0_ack}, 32'd1);
        chk("wr.m1_ack",    {31'd0, m1_ack}, 32'd0);
        chk("wr.we_once",   {31'd0, bus_we}, 32'd0);
        chk("wr.addr_done", bus_addr,        32'd0);
        m0_req = 1'b0;
        step();
        chk("wr.ack_once",  {31'd0, m0_ack}, 32'd0);

        // Lone m1 read; data changes between the two XFER cycles, last one is captured.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hF000_0000; bus_rdata = 32'h1111_1111;
        step();
        chk("rd.x0_addr",   bus_addr,        32'hF000_0000);
        chk("rd.x0_we",     {31'd0, bus_we}, 32'd0);
        chk("rd.x0_ack",    {31'd0, m1_ack}, 32'd0);
        bus_rdata = 32'h0000_A5FF;
        step();
        chk("rd.x1_addr",   bus_addr,        32'hF000_0000);
        chk("rd.x1_we",     {31'd0, bus_we}, 32'd0);
        chk("rd.x1_ack",    {31'd0, m1_ack}, 32'd0);
        step();
        chk("rd.m1_ack",    {31'd0, m1_ack}, 32'd1);
        chk("rd.m0_ack",    {31'd0, m0_ack}, 32'd0);
        chk("rd.m1_rdata",  m1_rdata,        32'h0000_A5FF);
        chk("rd.m0_rdata",  m0_rdata,        32'd0);
        m1_req = 1'b0;
        step();

        // Simultaneous held requests after reset alternate m0, m1, m0, m1.
        do_reset();
        chk("rst2.m1_rdata", m1_rdata, 32'd0);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = 32'hA0A0_A0A0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0200; m1_wdata = 32'hB1B1_B1B1;
        for (int i = 0; i < 4; i++) begin
            own = (i % 2 == 1);
            step();
            chk($sformatf("rr%0d.addr", i),  bus_addr,  own ? 32'h0000_0200 : 32'h0000_0100);
            chk($sformatf("rr%0d.wdata", i), bus_wdata, own ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0);
            chk($sformatf("rr%0d.we", i),    {31'd0, bus_we}, 32'd1);
            step();
            chk($sformatf("rr%0d.m0_ack", i), {31'd0, m0_ack}, own ? 32'd0 : 32'd1);
            chk($sformatf("rr%0d.m1_ack", i), {31'd0, m1_ack}, own ? 32'd1 : 32'd0);
            if (i == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            step();
            chk($sformatf("rr%0d.idle_ack", i), {31'd0, m0_ack | m1_ack}, 32'd0);
        end
        step();
        chk("rr.quiet_we",   {31'd0, bus_we}, 32'd0);
        chk("rr.quiet_addr", bus_addr,        32'd0);

        // m0 read drops req mid-XFER but still completes.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0040; bus_rdata = 32'h1234_5678;
        step();
        chk("drop.x0_addr", bus_addr, 32'h0000_0040);
        m0_req = 1'b0;
        step();
        chk("drop.x1_addr", bus_addr, 32'h0000_0040);
        step();
        chk("drop.m0_ack",   {31'd0, m0_ack}, 32'd1);
        chk("drop.m0_rdata", m0_rdata,        32'h1234_5678);
        chk("drop.m1_rdata", m1_rdata,        32'd0);
        step();
        chk("drop.ack_off",  {31'd0, m0_ack}, 32'd0);
        step();
        chk("drop.no_rpt",   {31'd0, m0_ack}, 32'd0);
        chk("drop.bus_idle", bus_addr,        32'd0);

        // m1 read whose inputs change after grant.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hE000_0000; m1_wdata = 32'd0;
        bus_rdata = 32'h5A5A_0001;
        step();
        chk("hold.x0_addr", bus_addr, 32'hE000_0000);
        m1_addr = 32'h0000_0000; m1_we = 1'b1; m1_wdata = 32'hFFFF_FFFF;
        step();
        chk("hold.x1_addr",  bus_addr,        32'hE000_0000);
        chk("hold.x1_we",    {31'd0, bus_we}, 32'd0);
        chk("hold.x1_wdata", bus_wdata,       32'd0);
        step();
        chk("hold.m1_ack",   {31'd0, m1_ack}, 32'd1);
        chk("hold.m1_rdata", m1_rdata,        32'h5A5A_0001);
        chk("hold.m0_rdata", m0_rdata,        32'h1234_5678);
        m1_req = 1'b0; m1_we = 1'b0;
        step();

        // Reset during a read XFER aborts it.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0080; bus_rdata = 32'h0BAD_0BAD;
        step();
        chk("abort.x0_addr", bus_addr, 32'h0000_0080);
        rst = 1'b1;
        step();
        chk_all_zero("abort");
        rst = 1'b0; m0_req = 1'b0;
        step();
        chk("abort.no_ack1", {31'd0, m0_ack | m1_ack}, 32'd0);
        chk("abort.no_we",   {31'd0, bus_we}, 32'd0);
        step();
        chk("abort.no_ack2", {31'd0, m0_ack | m1_ack}, 32'd0);

        // Normal service after the aborting reset.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0020; m0_wdata = 32'hCAFE_F00D;
        step();
        chk("post.bus_we",    {31'd0, bus_we}, 32'd1);
        chk("post.bus_addr",  bus_addr,        32'h0000_0020);
        chk("post.bus_wdata", bus_wdata,       32'hCAFE_F00D);
        step();
        chk("post.m0_ack",    {31'd0, m0_ack}, 32'd1);
        m0_req = 1'b0;
        step();
        chk("post.ack_off",   {31'd0, m0_ack}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
